// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: FSM state encoding.
package led_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_state_t;

endpackage

// File: rtl/led_prescaler.sv
// Tick generator: one-cycle tick every PRESCALE clocks, restarted by a synchronous clear.
module led_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt_reg;

  assign tick = (cnt_reg == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Status LED owner: arbitrates NREQ blink requests and drives led through ON/OFF/GAP phases.
// Optional build macro LED_SEQ_RR_EN selects round-robin instead of fixed-priority arbitration.
module led_sequencer
  import led_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int CNT_W     = 4,
  parameter int PRESCALE  = 4,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] count,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  led
);

  localparam int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS)
                           ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                           : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W      = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  led_state_t       state_reg;
  logic [CNT_W-1:0] remain_reg;
  logic [PH_W-1:0]  phase_reg;
  logic             tick;
  logic             phase_last;

  logic [CNT_W-1:0] count_field [NREQ];
  logic [NREQ-1:0]  win_onehot;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] start_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_count
    assign count_field[gi] = count[gi*CNT_W +: CNT_W];
  end

`ifdef LED_SEQ_RR_EN
  logic [IDX_W-1:0] rr_start_reg;
  assign start_idx = rr_start_reg;
`else
  assign start_idx = '0;
`endif

  // First requester found walking upward from start_idx (wrapping) wins.
  always_comb begin
    win_onehot = '0;
    win_valid  = 1'b0;
    win_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_valid && req[(int'(start_idx) + k) % NREQ]) begin
        win_valid  = 1'b1;
        win_idx    = IDX_W'((int'(start_idx) + k) % NREQ);
        win_onehot[(int'(start_idx) + k) % NREQ] = 1'b1;
      end
    end
  end

  led_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg == IDLE),
    .tick (tick)
  );

  always_comb begin
    phase_last = 1'b0;
    case (state_reg)
      ON:      phase_last = (phase_reg == PH_W'(ON_TICKS - 1));
      OFF:     phase_last = (phase_reg == PH_W'(OFF_TICKS - 1));
      GAP:     phase_last = (phase_reg == PH_W'(GAP_TICKS - 1));
      default: phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      remain_reg <= '0;
      phase_reg  <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      led        <= 1'b0;
`ifdef LED_SEQ_RR_EN
      rr_start_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= '0;
          // The done cycle is a mandatory idle slot; arbitration waits one edge.
          if (done == '0 && win_valid) begin
            grant      <= win_onehot;
            busy       <= 1'b1;
            remain_reg <= count_field[win_idx];
            phase_reg  <= '0;
            if (count_field[win_idx] == '0) begin
              state_reg <= GAP;
              led       <= 1'b0;
            end else begin
              state_reg <= ON;
              led       <= 1'b1;
            end
`ifdef LED_SEQ_RR_EN
            rr_start_reg <= (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
          end
        end
        ON: begin
          if (tick) begin
            if (phase_last) begin
              phase_reg <= '0;
              led       <= 1'b0;
              if (remain_reg != '0) remain_reg <= remain_reg - 1'b1;
              state_reg <= (remain_reg <= CNT_W'(1)) ? GAP : OFF;
            end else begin
              phase_reg <= phase_reg + 1'b1;
            end
          end
        end
        OFF: begin
          if (tick) begin
            if (phase_last) begin
              phase_reg <= '0;
              led       <= 1'b1;
              state_reg <= ON;
            end else begin
              phase_reg <= phase_reg + 1'b1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (phase_last) begin
              phase_reg <= '0;
              state_reg <= IDLE;
              busy      <= 1'b0;
              done      <= grant;
              grant     <= '0;
            end else begin
              phase_reg <= phase_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
